iccm_boot_loader: RTL and testbench

Parametrised successor to the single-width UART ICCM programmer. It assembles a byte stream from the boot UART receiver into DATA_WIDTH-bit words and writes them sequentially into the instruction SRAM port, starting at address 0. The system reset is held while a load is in progress. A load ends on a terminator word; address-space overflow is detected and reported. The block sits between the boot UART receiver and the ICCM adapter's controller-write port, and drives the program reset into the reset manager.

---
 rtl/iccm_boot_loader.sv | 204 ++++++++++++++++++++
 tb/tb_iccm_boot_loader.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/iccm_boot_loader.sv
// Boot loader: packs UART bytes little-endian into ICCM words and writes them from address 0 up.
// The optional trailing checksum byte check is enabled by defining ICCM_BOOT_LOADER_CHECKSUM_EN.
module iccm_boot_loader #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 11,
  parameter logic [63:0] END_WORD   = 64'h0000_0000_0000_0FFF
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  prog_i,
  input  logic                  rx_dv_i,
  input  logic [7:0]            rx_byte_i,
  output logic                  we_o,
  output logic [ADDR_WIDTH-1:0] addr_o,
  output logic [DATA_WIDTH-1:0] wdata_o,
  output logic                  prog_rst_no,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  err_o,
  output logic [ADDR_WIDTH:0]   word_cnt_o
);

  localparam int unsigned           NB       = DATA_WIDTH / 8;
  localparam int unsigned           IDX_W    = (NB > 1) ? $clog2(NB) : 1;
  localparam logic [DATA_WIDTH-1:0] END_W    = END_WORD[DATA_WIDTH-1:0];
  localparam logic [IDX_W-1:0]      LAST_IDX = IDX_W'(NB - 1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_MAX = '1;

  typedef enum logic [2:0] {S_IDLE, S_RECV, S_WRITE, S_DONE, S_ERR, S_CSUM} state_t;

  state_t                state_reg;
  logic [DATA_WIDTH-1:0] asm_reg;
  logic [DATA_WIDTH-1:0] asm_next;
  logic [IDX_W-1:0]      byte_idx_reg;
  logic                  full_reg;
  logic                  full_next;
  logic                  rx_take;
  logic                  eval;

  // Bytes are accepted in WRITE too, so the assembly register keeps filling while a word is written.
  assign rx_take = rx_dv_i && (state_reg == S_RECV || state_reg == S_WRITE);
  assign eval    = (state_reg == S_RECV) && full_reg && prog_i;

  genvar gi;
  for (gi = 0; gi < NB; gi++) begin : g_lane
    assign asm_next[8*gi +: 8] = (rx_take && byte_idx_reg == IDX_W'(gi)) ? rx_byte_i
                                                                         : asm_reg[8*gi +: 8];
  end

  always_comb begin
    full_next = full_reg;
    if (eval)
      full_next = 1'b0;
    if (rx_take && byte_idx_reg == LAST_IDX)
      full_next = 1'b1;
  end

`ifdef ICCM_BOOT_LOADER_CHECKSUM_EN
  logic [7:0] csum_reg;
  logic [7:0] word_sum;

  always_comb begin
    word_sum = 8'h00;
    for (int i = 0; i < int'(NB); i++)
      word_sum = word_sum + asm_reg[8*i +: 8];
  end
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg    <= S_IDLE;
      asm_reg      <= '0;
      byte_idx_reg <= '0;
      full_reg     <= 1'b0;
      we_o         <= 1'b0;
      addr_o       <= '0;
      wdata_o      <= '0;
      prog_rst_no  <= 1'b1;
      busy_o       <= 1'b0;
      done_o       <= 1'b0;
      err_o        <= 1'b0;
      word_cnt_o   <= '0;
`ifdef ICCM_BOOT_LOADER_CHECKSUM_EN
      csum_reg     <= 8'h00;
`endif
    end else begin
      if (rx_take) begin
        asm_reg      <= asm_next;
        byte_idx_reg <= (byte_idx_reg == LAST_IDX) ? '0 : byte_idx_reg + IDX_W'(1);
      end
      full_reg <= full_next;
      we_o     <= 1'b0;

      case (state_reg)
        S_IDLE: begin
          if (prog_i) begin
            state_reg    <= S_RECV;
            addr_o       <= '0;
            byte_idx_reg <= '0;
            full_reg     <= 1'b0;
            word_cnt_o   <= '0;
            done_o       <= 1'b0;
            err_o        <= 1'b0;
            prog_rst_no  <= 1'b0;
            busy_o       <= 1'b1;
`ifdef ICCM_BOOT_LOADER_CHECKSUM_EN
            csum_reg     <= 8'h00;
`endif
          end
        end

        S_RECV: begin
          if (!prog_i) begin
            state_reg   <= S_IDLE;
            prog_rst_no <= 1'b1;
            busy_o      <= 1'b0;
          end else if (full_reg) begin
            if (asm_reg == END_W) begin
`ifdef ICCM_BOOT_LOADER_CHECKSUM_EN
              // A checksum byte landing in the evaluation cycle is compared right away.
              if (rx_dv_i) begin
                busy_o <= 1'b0;
                if (rx_byte_i == csum_reg) begin
                  state_reg   <= S_DONE;
                  done_o      <= 1'b1;
                  prog_rst_no <= 1'b1;
                end else begin
                  state_reg <= S_ERR;
                  err_o     <= 1'b1;
                end
              end else begin
                state_reg <= S_CSUM;
              end
`else
              state_reg   <= S_DONE;
              busy_o      <= 1'b0;
              done_o      <= 1'b1;
              prog_rst_no <= 1'b1;
`endif
            end else begin
              state_reg <= S_WRITE;
              wdata_o   <= asm_reg;
              we_o      <= 1'b1;
`ifdef ICCM_BOOT_LOADER_CHECKSUM_EN
              csum_reg  <= csum_reg + word_sum;
`endif
            end
          end
        end

        S_WRITE: begin
          word_cnt_o <= word_cnt_o + (ADDR_WIDTH+1)'(1);
          if (!prog_i) begin
            state_reg   <= S_IDLE;
            prog_rst_no <= 1'b1;
            busy_o      <= 1'b0;
          end else if (addr_o == ADDR_MAX) begin
            state_reg <= S_ERR;
            busy_o    <= 1'b0;
            err_o     <= 1'b1;
          end else begin
            addr_o    <= addr_o + ADDR_WIDTH'(1);
            state_reg <= S_RECV;
          end
        end

`ifdef ICCM_BOOT_LOADER_CHECKSUM_EN
        S_CSUM: begin
          if (!prog_i) begin
            state_reg   <= S_IDLE;
            prog_rst_no <= 1'b1;
            busy_o      <= 1'b0;
          end else if (rx_dv_i) begin
            busy_o <= 1'b0;
            if (rx_byte_i == csum_reg) begin
              state_reg   <= S_DONE;
              done_o      <= 1'b1;
              prog_rst_no <= 1'b1;
            end else begin
              state_reg <= S_ERR;
              err_o     <= 1'b1;
            end
          end
        end
`endif

        S_DONE: begin
          if (!prog_i)
            state_reg <= S_IDLE;
        end

        S_ERR: begin
          if (!prog_i) begin
            state_reg   <= S_IDLE;
            prog_rst_no <= 1'b1;
          end
        end

        default: state_reg <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_iccm_boot_loader.sv
// Directed bench for iccm_boot_loader: a default instance plus a 4-word-deep instance for overflow.
// Runs the checksum scenario when ICCM_BOOT_LOADER_CHECKSUM_EN is defined.
module tb_iccm_boot_loader;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       prog;
  logic       rx_dv;
  logic       sel;
  logic [7:0] rx_byte;
  logic [7:0] csum_unused;

  always #5 clk = ~clk;

  logic        we_a, prst_a, busy_a, done_a, err_a;
  logic [10:0] addr_a;
  logic [31:0] wdata_a;
  logic [11:0] cnt_a;

  logic        we_b, prst_b, busy_b, done_b, err_b;
  logic [1:0]  addr_b;
  logic [31:0] wdata_b;
  logic [2:0]  cnt_b;

  iccm_boot_loader u_dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .prog_i     (prog & ~sel),
    .rx_dv_i    (rx_dv & ~sel),
    .rx_byte_i  (rx_byte),
    .we_o       (we_a),
    .addr_o     (addr_a),
    .wdata_o    (wdata_a),
    .prog_rst_no(prst_a),
    .busy_o     (busy_a),
    .done_o     (done_a),
    .err_o      (err_a),
    .word_cnt_o (cnt_a)
  );

  iccm_boot_loader #(.ADDR_WIDTH(2)) u_small (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .prog_i     (prog & sel),
    .rx_dv_i    (rx_dv & sel),
    .rx_byte_i  (rx_byte),
    .we_o       (we_b),
    .addr_o     (addr_b),
    .wdata_o    (wdata_b),
    .prog_rst_no(prst_b),
    .busy_o     (busy_b),
    .done_o     (done_b),
    .err_o      (err_b),
    .word_cnt_o (cnt_b)
  );

  int          wa_addr[$];
  logic [31:0] wa_data[$];
  int          wb_addr[$];
  logic [31:0] wb_data[$];

  always @(negedge clk) begin
    if (we_a) begin
      wa_addr.push_back(int'(addr_a));
      wa_data.push_back(wdata_a);
      $display("write dut=a addr=%0d data=%h", addr_a, wdata_a);
    end
    if (we_b) begin
      wb_addr.push_back(int'(addr_b));
      wb_data.push_back(wdata_b);
      $display("write dut=b addr=%0d data=%h", addr_b, wdata_b);
    end
  end

  int n_total  = 0;
  int n_passed = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got === exp) n_passed++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    rx_dv   = 1'b1;
    rx_byte = b;
    tick();
    rx_dv = 1'b0;
    tick(gap);
  endtask

  task automatic send_word(input logic [31:0] w, input int gap);
    logic [7:0] b;
    for (int k = 0; k < 4; k++) begin
      b = w[8*k +: 8];
      send_byte(b, gap);
    end
  endtask

  task automatic send_term(input logic [7:0] csum);
    send_word(32'h0000_0FFF, 2);
`ifdef ICCM_BOOT_LOADER_CHECKSUM_EN
    send_byte(csum, 2);
`else
    csum_unused = csum;
`endif
  endtask

  int n0;

  initial begin
    rst_n = 1'b1; prog = 1'b0; rx_dv = 1'b0; sel = 1'b0; rx_byte = 8'h00; csum_unused = 8'h00;
    #2 rst_n = 1'b0;
    #10;
    check("rst_we",   we_a,    0);
    check("rst_addr", addr_a,  0);
    check("rst_data", wdata_a, 0);
    check("rst_prst", prst_a,  1);
    check("rst_busy", busy_a,  0);
    check("rst_done", done_a,  0);
    check("rst_err",  err_a,   0);
    check("rst_cnt",  cnt_a,   0);
    check("rst_prst_b", prst_b, 1);
    #1 rst_n = 1'b1;
    tick();

    // 1: two words then terminator
    prog = 1'b1; tick();
    check("t1_busy", busy_a, 1);
    check("t1_prst_low", prst_a, 0);
    n0 = wa_addr.size();
    send_word(32'h0000_0513, 2);
    send_word(32'h2000_0137, 2);
    send_term(8'h70);
    tick(3);
    check("t1_nwr", wa_addr.size() - n0, 2);
    if (wa_addr.size() - n0 >= 2) begin
      check("t1_a0", wa_addr[n0],   0);
      check("t1_d0", wa_data[n0],   32'h0000_0513);
      check("t1_a1", wa_addr[n0+1], 1);
      check("t1_d1", wa_data[n0+1], 32'h2000_0137);
    end
    check("t1_done", done_a, 1);
    check("t1_prst", prst_a, 1);
    check("t1_cnt",  cnt_a,  2);
    check("t1_busy_end", busy_a, 0);
    prog = 1'b0; tick(2);
    check("t1_done_idle", done_a, 1);

    // 2: back-to-back bytes
    prog = 1'b1; tick();
    n0 = wa_addr.size();
    for (int b = 8'hAA; b <= 8'hB1; b++) send_byte(8'(b), 0);
    tick(3);
    check("t2_nwr", wa_addr.size() - n0, 2);
    if (wa_addr.size() - n0 >= 2) begin
      check("t2_a0", wa_addr[n0],   0);
      check("t2_d0", wa_data[n0],   32'hADAC_ABAA);
      check("t2_a1", wa_addr[n0+1], 1);
      check("t2_d1", wa_data[n0+1], 32'hB1B0_AFAE);
    end
    send_term(8'h6C);
    tick(3);
    check("t2_done", done_a, 1);
    check("t2_cnt",  cnt_a,  2);
    prog = 1'b0; tick(2);

    // 3: overflow on the 2-bit-address instance
    sel = 1'b1; prog = 1'b1; tick();
    n0 = wb_addr.size();
    send_word(32'h1111_1111, 2);
    send_word(32'h2222_2222, 2);
    send_word(32'h3333_3333, 2);
    send_word(32'h4444_4444, 2);
    tick(3);
    check("t3_nwr", wb_addr.size() - n0, 4);
    for (int k = 0; k < 4; k++) begin
      if (wb_addr.size() - n0 > k) begin
        check($sformatf("t3_a%0d", k), wb_addr[n0+k], k);
        check($sformatf("t3_d%0d", k), wb_data[n0+k], 32'h1111_1111 * (k + 1));
      end
    end
    check("t3_err",  err_b,  1);
    check("t3_done", done_b, 0);
    check("t3_prst", prst_b, 0);
    check("t3_cnt",  cnt_b,  4);
    check("t3_addr_held", addr_b, 3);
    prog = 1'b0; tick(2);
    check("t3_prst_rel", prst_b, 1);
    check("t3_err_hold", err_b, 1);
    sel = 1'b0;

    // 4: abort after half a word
    prog = 1'b1; tick();
    n0 = wa_addr.size();
    send_byte(8'h13, 1);
    send_byte(8'h05, 1);
    prog = 1'b0; tick(4);
    check("t4_nwr", wa_addr.size() - n0, 0);
    check("t4_prst", prst_a, 1);
    check("t4_done", done_a, 0);
    check("t4_err",  err_a,  0);
    check("t4_busy", busy_a, 0);

    // 5: asynchronous reset mid-load, then reload from address 0
    prog = 1'b1; tick();
    send_word(32'h0000_0513, 2);
    tick(2);
    send_byte(8'h37, 1);
    #2 rst_n = 1'b0;
    #1;
    check("t5_prst", prst_a,  1);
    check("t5_busy", busy_a,  0);
    check("t5_addr", addr_a,  0);
    check("t5_data", wdata_a, 0);
    check("t5_cnt",  cnt_a,   0);
    check("t5_we",   we_a,    0);
    #2 rst_n = 1'b1;
    tick();
    n0 = wa_addr.size();
    send_word(32'hCAFE_0001, 2);
    tick(2);
    check("t5_nwr", wa_addr.size() - n0, 1);
    if (wa_addr.size() - n0 >= 1) begin
      check("t5_a0", wa_addr[n0], 0);
      check("t5_d0", wa_data[n0], 32'hCAFE_0001);
    end
    send_term(8'hC9);
    tick(3);
    check("t5_done", done_a, 1);
    check("t5_cnt",  cnt_a,  1);
    prog = 1'b0; tick(2);

`ifdef ICCM_BOOT_LOADER_CHECKSUM_EN
    // 6: checksum good, then bad
    prog = 1'b1; tick();
    send_word(32'h0000_0513, 2);
    send_word(32'h0000_0FFF, 2);
    check("t6_busy_csum", busy_a, 1);
    send_byte(8'h18, 2);
    tick(2);
    check("t6_done", done_a, 1);
    check("t6_err0", err_a,  0);
    prog = 1'b0; tick(2);
    prog = 1'b1; tick();
    send_word(32'h0000_0513, 2);
    send_word(32'h0000_0FFF, 2);
    send_byte(8'h19, 2);
    tick(2);
    check("t6_err",   err_a,  1);
    check("t6_prst",  prst_a, 0);
    check("t6_done0", done_a, 0);
    prog = 1'b0; tick(2);
`endif

    $display("%0d/%0d checks passed", n_passed, n_total);
    $finish;
  end

endmodule
